// File: rtl/time_set_ctrl.sv
// time_set_ctrl: run/set mode sequencer for the 12h clock counter chain.
// Turns debounced buttons into advance pulses with hold auto-repeat,
// idle timeout back to RUN, seconds gating and field blink enables.
//
// Ports:
//   clk, rst (sync, active-high)
//   btn_mode     rising edge steps RUN -> SET_HR -> SET_MIN -> ...
//   btn_adv      rising edge / hold advances the field being set
//   run_enb      seconds tick may reach the counter chain
//   clr_sec      1-cycle clear of seconds on leaving SET_MIN
//   adv_min      1-cycle advance pulse for minutes
//   adv_hr       1-cycle advance pulse for hours
//   blink_min    blank minute digits this phase
//   blink_hr     blank hour digits this phase
//   alm_adv_min  1-cycle alarm-minute advance (alarm build only)
//   alm_adv_hr   1-cycle alarm-hour advance (alarm build only)
//   mode         current state: RUN=0 SET_HR=1 SET_MIN=2 ALM_HR=3 ALM_MIN=4
//
// Build option: define ALARM_SET_EN to add the ALM_HR/ALM_MIN set states.

module time_set_ctrl #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int HOLD_MS    = 500,
    parameter int REPEAT_MS  = 200,
    parameter int TIMEOUT_MS = 10_000,
    parameter int BLINK_MS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_adv,
    output logic       run_enb,
    output logic       clr_sec,
    output logic       adv_min,
    output logic       adv_hr,
    output logic       blink_min,
    output logic       blink_hr,
    output logic       alm_adv_min,
    output logic       alm_adv_hr,
    output logic [2:0] mode
);

    localparam int DIV    = CLK_HZ / 1000;
    localparam int DW     = $clog2(DIV + 1);
    localparam int RMAX   = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int RW     = $clog2(RMAX + 1);
    localparam int TW     = $clog2(TIMEOUT_MS + 1);
    localparam int BW     = $clog2(BLINK_MS + 1);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_ALM_HR  = 3'd3,
        ST_ALM_MIN = 3'd4
    } state_t;

    state_t        state, state_n, nxt;
    logic [DW-1:0] div_cnt, div_n;
    logic [RW-1:0] rep_cnt, rep_cnt_n;
    logic          rep_on, rep_on_n;
    logic [TW-1:0] idle_cnt, idle_cnt_n;
    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          phase, phase_n;
    logic          mode_q, adv_q;
    logic          ms_tick, mode_edge, adv_edge, fire;
    logic          run_enb_n, clr_sec_n, adv_min_n, adv_hr_n;
    logic          blink_min_n, blink_hr_n, alm_adv_min_n, alm_adv_hr_n;
    logic          hr_view, min_view;

    assign ms_tick   = (div_cnt == DW'(DIV - 1));
    assign mode_edge = btn_mode & ~mode_q;
    assign adv_edge  = btn_adv & ~adv_q;
    assign mode      = state;

    always_comb begin
        case (state)
            ST_RUN:     nxt = ST_SET_HR;
            ST_SET_HR:  nxt = ST_SET_MIN;
`ifdef ALARM_SET_EN
            ST_SET_MIN: nxt = ST_ALM_HR;
            ST_ALM_HR:  nxt = ST_ALM_MIN;
`endif
            default:    nxt = ST_RUN;
        endcase
    end

    always_comb begin
        state_n     = state;
        div_n       = ms_tick ? '0 : div_cnt + 1'b1;
        rep_cnt_n   = rep_cnt;
        rep_on_n    = rep_on;
        idle_cnt_n  = idle_cnt;
        blink_cnt_n = blink_cnt;
        phase_n     = phase;
        fire        = 1'b0;
        clr_sec_n   = 1'b0;

        if (mode_edge) begin
            // mode change beats any advance due this cycle
            state_n    = nxt;
            rep_cnt_n  = '0;
            rep_on_n   = 1'b0;
            idle_cnt_n = '0;
            clr_sec_n  = (state == ST_SET_MIN);
        end else if (state != ST_RUN) begin
            if (!btn_adv || adv_edge) begin
                rep_cnt_n = '0;
                rep_on_n  = 1'b0;
                fire      = adv_edge;
            end else if (ms_tick) begin
                // first the hold delay, then the repeat period
                if (!rep_on) begin
                    if (rep_cnt == RW'(HOLD_MS - 1)) begin
                        fire      = 1'b1;
                        rep_on_n  = 1'b1;
                        rep_cnt_n = '0;
                    end else begin
                        rep_cnt_n = rep_cnt + 1'b1;
                    end
                end else if (rep_cnt == RW'(REPEAT_MS - 1)) begin
                    fire      = 1'b1;
                    rep_cnt_n = '0;
                end else begin
                    rep_cnt_n = rep_cnt + 1'b1;
                end
            end

            if (btn_adv) begin
                idle_cnt_n = '0;
            end else if (ms_tick) begin
                if (idle_cnt == TW'(TIMEOUT_MS - 1)) begin
                    state_n    = ST_RUN;
                    idle_cnt_n = '0;
                end else begin
                    idle_cnt_n = idle_cnt + 1'b1;
                end
            end
        end else begin
            rep_cnt_n  = '0;
            rep_on_n   = 1'b0;
            idle_cnt_n = '0;
        end

        // an advance restarts the half-period with digits shown
        if (fire) begin
            blink_cnt_n = '0;
            phase_n     = 1'b0;
        end else if (ms_tick) begin
            if (blink_cnt == BW'(BLINK_MS - 1)) begin
                blink_cnt_n = '0;
                phase_n     = ~phase;
            end else begin
                blink_cnt_n = blink_cnt + 1'b1;
            end
        end

        adv_hr_n  = fire & (state == ST_SET_HR);
        adv_min_n = fire & (state == ST_SET_MIN);
`ifdef ALARM_SET_EN
        alm_adv_hr_n  = fire & (state == ST_ALM_HR);
        alm_adv_min_n = fire & (state == ST_ALM_MIN);
        hr_view   = (state_n == ST_SET_HR) || (state_n == ST_ALM_HR);
        min_view  = (state_n == ST_SET_MIN) || (state_n == ST_ALM_MIN);
        run_enb_n = (state_n == ST_RUN) || (state_n == ST_ALM_HR) ||
                    (state_n == ST_ALM_MIN);
`else
        alm_adv_hr_n  = 1'b0;
        alm_adv_min_n = 1'b0;
        hr_view   = (state_n == ST_SET_HR);
        min_view  = (state_n == ST_SET_MIN);
        run_enb_n = (state_n == ST_RUN);
`endif
        blink_hr_n  = phase_n & hr_view;
        blink_min_n = phase_n & min_view;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            div_cnt     <= '0;
            rep_cnt     <= '0;
            rep_on      <= 1'b0;
            idle_cnt    <= '0;
            blink_cnt   <= '0;
            phase       <= 1'b0;
            mode_q      <= 1'b0;
            adv_q       <= 1'b0;
            run_enb     <= 1'b1;
            clr_sec     <= 1'b0;
            adv_min     <= 1'b0;
            adv_hr      <= 1'b0;
            blink_min   <= 1'b0;
            blink_hr    <= 1'b0;
            alm_adv_min <= 1'b0;
            alm_adv_hr  <= 1'b0;
        end else begin
            state       <= state_n;
            div_cnt     <= div_n;
            rep_cnt     <= rep_cnt_n;
            rep_on      <= rep_on_n;
            idle_cnt    <= idle_cnt_n;
            blink_cnt   <= blink_cnt_n;
            phase       <= phase_n;
            mode_q      <= btn_mode;
            adv_q       <= btn_adv;
            run_enb     <= run_enb_n;
            clr_sec     <= clr_sec_n;
            adv_min     <= adv_min_n;
            adv_hr      <= adv_hr_n;
            blink_min   <= blink_min_n;
            blink_hr    <= blink_hr_n;
            alm_adv_min <= alm_adv_min_n;
            alm_adv_hr  <= alm_adv_hr_n;
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: bench for time_set_ctrl.
// Table vectors, directed corner sequences and random stimulus vs a model.

module tb_time_set_ctrl;

    localparam int CLK_HZ = 10_000;
    localparam int DIV    = CLK_HZ / 1000;
    localparam int HOLD   = 5;
    localparam int REP    = 2;
    localparam int TOUT   = 20;
    localparam int BLINK  = 3;
`ifdef ALARM_SET_EN
    localparam int NST = 5;
    localparam bit ALM = 1'b1;
`else
    localparam int NST = 3;
    localparam bit ALM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_adv = 1'b0;
    logic       run_enb, clr_sec, adv_min, adv_hr;
    logic       blink_min, blink_hr, alm_adv_min, alm_adv_hr;
    logic [2:0] mode;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .CLK_HZ(CLK_HZ), .HOLD_MS(HOLD), .REPEAT_MS(REP),
        .TIMEOUT_MS(TOUT), .BLINK_MS(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_adv(btn_adv),
        .run_enb(run_enb), .clr_sec(clr_sec),
        .adv_min(adv_min), .adv_hr(adv_hr),
        .blink_min(blink_min), .blink_hr(blink_hr),
        .alm_adv_min(alm_adv_min), .alm_adv_hr(alm_adv_hr),
        .mode(mode)
    );

    int errors = 0;
    int checks = 0;

    // reference model: cycle index, ms ticks since press/idle/blink restart
    int m_state, m_pm, m_pa, m_cyc, m_k, m_idle, m_bt;
    logic [10:0] exp_vec;
    int cnt_hr, cnt_min, cnt_clr, cnt_ahr;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, want);
        end
    endtask

    task automatic model(input logic r, input logic bm, input logic ba);
        int  old, ph;
        bit  tick, me, ae, fire, clr, run;
        if (r) begin
            m_state = 0; m_pm = 0; m_pa = 0; m_cyc = 0;
            m_k = 0; m_idle = 0; m_bt = 0;
            exp_vec = {1'b1, 10'b0};
            return;
        end
        tick = ((m_cyc % DIV) == DIV - 1);
        me   = bm && (m_pm == 0);
        ae   = ba && (m_pa == 0);
        old  = m_state;
        fire = 0;
        clr  = 0;
        if (me) begin
            clr = (old == 2);
            m_state = (old + 1) % NST;
            m_k = 0;
            m_idle = 0;
        end else if (old != 0) begin
            if (!ba) m_k = 0;
            else if (ae) begin
                m_k = 0;
                fire = 1;
            end else if (tick) begin
                m_k++;
                fire = (m_k == HOLD) ||
                       (m_k > HOLD && ((m_k - HOLD) % REP) == 0);
            end
            if (ba) m_idle = 0;
            else if (tick) begin
                m_idle++;
                if (m_idle >= TOUT) begin
                    m_state = 0;
                    m_idle = 0;
                end
            end
        end else begin
            m_k = 0;
            m_idle = 0;
        end
        if (fire) m_bt = 0;
        else if (tick) m_bt++;
        ph  = (m_bt / BLINK) % 2;
        run = (m_state == 0) || (ALM && m_state >= 3);
        exp_vec = {run, clr,
                   fire && old == 4, fire && old == 3,
                   fire && old == 2, fire && old == 1,
                   (ph == 1) && (m_state == 2 || m_state == 4),
                   (ph == 1) && (m_state == 1 || m_state == 3),
                   3'(m_state)};
        m_pm = bm;
        m_pa = ba;
        m_cyc++;
    endtask

    task automatic step(input logic r, input logic bm, input logic ba);
        logic [10:0] got;
        rst = r;
        btn_mode = bm;
        btn_adv = ba;
        model(r, bm, ba);
        @(posedge clk);
        #1;
        got = {run_enb, clr_sec, alm_adv_min, alm_adv_hr,
               adv_min, adv_hr, blink_min, blink_hr, mode};
        checks++;
        if (got !== exp_vec) begin
            errors++;
            $display("FAIL model cyc=%0d got=%b exp=%b",
                     m_cyc, got, exp_vec);
        end
        cnt_hr  += int'(adv_hr);
        cnt_min += int'(adv_min);
        cnt_clr += int'(clr_sec);
        cnt_ahr += int'(alm_adv_hr);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic align();
        for (int i = 0; i < DIV && (m_cyc % DIV) != DIV - 1; i++)
            step(1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic       r, bm, ba;
        logic [2:0] mode;
        logic       run, clr, hr, mn;
    } vec_t;

    vec_t tbl[15];

    task automatic setv(input int i, input logic r, input logic bm,
                        input logic ba, input logic [2:0] md,
                        input logic run, input logic clr,
                        input logic hr, input logic mn);
        tbl[i] = '{r, bm, ba, md, run, clr, hr, mn};
    endtask

    initial begin : main
        logic [2:0] after3;
        logic [6:0] got7, exp7;
        int n;
        logic bm, ba, r;

        after3 = ALM ? 3'd3 : 3'd0;
        setv(0,  1, 0, 0, 3'd0, 1, 0, 0, 0);
        setv(1,  1, 0, 0, 3'd0, 1, 0, 0, 0);
        setv(2,  1, 0, 0, 3'd0, 1, 0, 0, 0);
        setv(3,  0, 0, 1, 3'd0, 1, 0, 0, 0);
        setv(4,  0, 0, 0, 3'd0, 1, 0, 0, 0);
        setv(5,  0, 0, 1, 3'd0, 1, 0, 0, 0);
        setv(6,  0, 1, 0, 3'd1, 0, 0, 0, 0);
        setv(7,  0, 0, 0, 3'd1, 0, 0, 0, 0);
        setv(8,  0, 0, 1, 3'd1, 0, 0, 1, 0);
        setv(9,  0, 0, 0, 3'd1, 0, 0, 0, 0);
        setv(10, 0, 1, 0, 3'd2, 0, 0, 0, 0);
        setv(11, 0, 0, 1, 3'd2, 0, 0, 0, 1);
        setv(12, 0, 0, 0, 3'd2, 0, 0, 0, 0);
        setv(13, 0, 1, 0, after3, 1, 1, 0, 0);
        setv(14, 0, 0, 0, after3, 1, 0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].r, tbl[i].bm, tbl[i].ba);
            got7 = {mode, run_enb, clr_sec, adv_hr, adv_min};
            exp7 = {tbl[i].mode, tbl[i].run, tbl[i].clr,
                    tbl[i].hr, tbl[i].mn};
            checks++;
            if (got7 !== exp7) begin
                errors++;
                $display("FAIL table row=%0d got=%b exp=%b", i, got7, exp7);
            end
        end

        // hold 11 ms in SET_MIN: edge + 5 ms + 7, 9, 11 ms
        do_reset();
        step(0, 1, 0); step(0, 0, 0);
        step(0, 1, 0); step(0, 0, 0);
        chk("hold_in_setmin", int'(mode), 2);
        align();
        cnt_hr = 0; cnt_min = 0;
        for (int i = 0; i < 115; i++) step(0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        chk("hold_adv_min_count", cnt_min, 5);
        chk("hold_adv_hr_count", cnt_hr, 0);

        cnt_clr = 0;
        step(0, 1, 0);
        chk("exit_setmin_mode", int'(mode), int'(after3));
        chk("exit_setmin_run", int'(run_enb), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("exit_setmin_clr_count", cnt_clr, 1);

        // idle timeout from SET_HR
        do_reset();
        step(0, 1, 0);
        cnt_clr = 0;
        n = 0;
        while (mode != 3'd0 && n < 300) begin
            step(0, 0, 0);
            n++;
        end
        chk("timeout_mode", int'(mode), 0);
        chk("timeout_no_clr", cnt_clr, 0);
        chk("timeout_window", int'(n >= 190 && n <= 201), 1);

        // mode edge in the same cycle as a due repeat pulse
        do_reset();
        step(0, 1, 0); step(0, 0, 0);
        align();
        cnt_hr = 0; cnt_min = 0;
        step(0, 0, 1);
        for (int i = 0; i < 49; i++) step(0, 0, 1);
        step(0, 1, 1);
        chk("conflict_mode", int'(mode), 2);
        chk("conflict_no_adv", int'({adv_hr, adv_min}), 0);
        chk("conflict_hr_count", cnt_hr, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        chk("conflict_min_count", cnt_min, 0);

`ifdef ALARM_SET_EN
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0); step(0, 0, 0);
        end
        chk("alarm_mode3", int'(mode), 3);
        cnt_ahr = 0;
        step(0, 0, 1); step(0, 0, 0);
        chk("alarm_adv_hr_count", cnt_ahr, 1);
        step(0, 1, 0);
        chk("alarm_mode4", int'(mode), 4);
`endif

        // random stimulus against the model
        do_reset();
        bm = 0;
        ba = 0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(1499) == 0);
            if ($urandom_range(119) == 0) bm = ~bm;
            if ($urandom_range(149) == 0) ba = ~ba;
            step(r, bm, ba);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
